pipelined_cla_adder: RTL

//  Parametrised, pipelined carry-lookahead add/subtract unit. Successor to the

---
 rtl/pipelined_cla_adder_if.sv | 36 +++
 rtl/pipelined_cla_adder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_cla_adder_if
//  Description : Operand/result handshake bundle for pipelined_cla_adder.
//                The master side produces operands and consumes results.
//                The slave side is the adder itself.
//  Signals     : valid_in/ready_out/a_in/b_in/c_in/sub_in  operand channel
//                valid_out/ready_in/s_out/c_out/ovf_out    result channel
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_cla_adder_if #(
  parameter int NUMBITS = 8
);
  logic               valid_in;
  logic               ready_out;
  logic [NUMBITS-1:0] a_in;
  logic [NUMBITS-1:0] b_in;
  logic               c_in;
  logic               sub_in;
  logic               valid_out;
  logic               ready_in;
  logic [NUMBITS-1:0] s_out;
  logic               c_out;
  logic               ovf_out;

  modport master (
    output valid_in, a_in, b_in, c_in, sub_in, ready_in,
    input  ready_out, valid_out, s_out, c_out, ovf_out
  );

  modport slave (
    input  valid_in, a_in, b_in, c_in, sub_in, ready_in,
    output ready_out, valid_out, s_out, c_out, ovf_out
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_cla_adder
//  Description : Pipelined carry-lookahead add/subtract unit. The NUMBITS
//                datapath is split into STAGES slices of W = NUMBITS/STAGES
//                bits; slice k is resolved by a CLA in pipeline stage k.
//                Full-rate valid/ready handshake, latency STAGES clocks.
//  Parameters  : NUMBITS  operand/result width (multiple of STAGES)
//                STAGES   pipeline depth, 1..NUMBITS
//  Ports       : clk_in    clock, rising edge
//                reset_in  synchronous active-high reset
//                bus       slave side of pipelined_cla_adder_if:
//                          valid_in/ready_out, a_in, b_in, c_in, sub_in,
//                          valid_out/ready_in, s_out, c_out, ovf_out
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_cla_adder #(
  parameter int NUMBITS = 8,
  parameter int STAGES  = 2
) (
  input  wire logic            clk_in,
  input  wire logic            reset_in,
  pipelined_cla_adder_if.slave bus
);

  localparam int W    = NUMBITS / STAGES;
  localparam int LAST = STAGES - 1;

  logic               advance;
  logic [NUMBITS-1:0] b_eff;
  logic               c_eff;
  logic               ovf_d;
  logic               ovf_q;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      // IN_W: operand bits still unresolved when entering this stage.
      // REM_W: operand bits that must travel on to later stages.
      localparam int IN_W  = NUMBITS - k * W;
      localparam int REM_W = IN_W - W;
      localparam int SUM_W = (k + 1) * W;

      logic [IN_W-1:0]  up_a;
      logic [IN_W-1:0]  up_b;
      logic             cin;
      logic             vin;
      logic [SUM_W-1:0] sum_new;
      logic [W-1:0]     gen;
      logic [W-1:0]     prop;
      logic [W-1:0]     sum_slice;
      logic [W:0]       carry;
      logic             la_c;
      logic             la_p;
      logic             valid_d;
      logic             valid_q;
      logic             carry_d;
      logic             carry_q;
      logic [SUM_W-1:0] sum_d;
      logic [SUM_W-1:0] sum_q;

      if (k == 0) begin : g_src
        assign up_a    = bus.a_in;
        assign up_b    = b_eff;
        assign cin     = c_eff;
        assign vin     = bus.valid_in;
        assign sum_new = sum_slice;
      end else begin : g_src
        assign up_a    = g_stage[k-1].g_ops.a_rem_q;
        assign up_b    = g_stage[k-1].g_ops.b_rem_q;
        assign cin     = g_stage[k-1].carry_q;
        assign vin     = g_stage[k-1].valid_q;
        // Finished lower slices ride along under the new one.
        assign sum_new = {sum_slice, g_stage[k-1].sum_q};
      end

      // Lookahead: every carry is expanded directly from generate/propagate
      // terms and the slice carry-in, not rippled from the previous bit.
      always_comb begin
        gen      = up_a[W-1:0] & up_b[W-1:0];
        prop     = up_a[W-1:0] ^ up_b[W-1:0];
        carry    = '0;
        la_c     = 1'b0;
        la_p     = 1'b0;
        carry[0] = cin;
        for (int i = 0; i < W; i++) begin
          la_c = gen[i];
          la_p = prop[i];
          for (int j = i - 1; j >= 0; j--) begin
            la_c = la_c | (la_p & gen[j]);
            la_p = la_p & prop[j];
          end
          carry[i+1] = la_c | (la_p & cin);
        end
        sum_slice = prop ^ carry[W-1:0];
      end

      always_comb begin
        valid_d = valid_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        if (advance) begin
          valid_d = vin;
          carry_d = carry[W];
          sum_d   = sum_new;
        end
      end

      always_ff @(posedge clk_in) begin
        if (reset_in) begin
          valid_q <= 1'b0;
          carry_q <= 1'b0;
          sum_q   <= '0;
        end else begin
          valid_q <= valid_d;
          carry_q <= carry_d;
          sum_q   <= sum_d;
        end
      end

      // Upper operand bits, skewed one stage per slice.
      if (REM_W > 0) begin : g_ops
        logic [REM_W-1:0] a_rem_d;
        logic [REM_W-1:0] a_rem_q;
        logic [REM_W-1:0] b_rem_d;
        logic [REM_W-1:0] b_rem_q;

        always_comb begin
          a_rem_d = a_rem_q;
          b_rem_d = b_rem_q;
          if (advance) begin
            a_rem_d = up_a[IN_W-1:W];
            b_rem_d = up_b[IN_W-1:W];
          end
        end

        always_ff @(posedge clk_in) begin
          if (reset_in) begin
            a_rem_q <= '0;
            b_rem_q <= '0;
          end else begin
            a_rem_q <= a_rem_d;
            b_rem_q <= b_rem_d;
          end
        end
      end
    end
  endgenerate

  // Subtraction is A + ~B + ~borrow, so the carry-out reads as "no borrow".
  always_comb begin
    advance = !g_stage[LAST].valid_q || bus.ready_in;
    b_eff   = bus.sub_in ? ~bus.b_in : bus.b_in;
    c_eff   = bus.sub_in ? ~bus.c_in : bus.c_in;
  end

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (advance) begin
      ovf_d = g_stage[LAST].carry[W] ^ g_stage[LAST].carry[W-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ready_out = advance;
  assign bus.valid_out = g_stage[LAST].valid_q;
  assign bus.s_out     = g_stage[LAST].sum_q;
  assign bus.c_out     = g_stage[LAST].carry_q;
  assign bus.ovf_out   = ovf_q;

endmodule
`default_nettype wire
